spi_fifo_arbiter: RTL and testbench
===================================

SPI_FIFO_ARBITER -- requirements
Module: spi_fifo_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: word width of every data path.
REQ-002 Parameter NUM_REQ, default 2: number of requesters sharing one FIFO write port; legal range 2..8.
REQ-003 Parameter LEN_WIDTH, default 4: width of each burst-length field.
REQ-004 clk_i  input  1: single clock; every flop is rising-edge.
REQ-005 rst_ni  input  1: reset, asynchronous assert, active-low.
REQ-006 clr_i  input  1: synchronous soft clear.
REQ-007 req_i  input  NUM_REQ: per-requester burst request; level signal held until done_o or abort.
REQ-008 len_i  input  NUM_REQ*LEN_WIDTH: per-requester burst length minus one; requester k uses slice [k*LEN_WIDTH +: LEN_WIDTH].
REQ-009 valid_i  input  NUM_REQ: per-requester data valid.
REQ-010 data_i  input  NUM_REQ*DATA_WIDTH: per-requester data; requester k uses slice [k*DATA_WIDTH +: DATA_WIDTH].
REQ-011 ready_o  output  NUM_REQ: per-requester data ready.
REQ-012 gnt_o  output  NUM_REQ: registered one-hot grant.
REQ-013 done_o  output  NUM_REQ: one-cycle pulse marking burst completion.
REQ-014 abort_o  output  1: one-cycle pulse marking burst abort.
REQ-015 busy_o  output  1: high while in XFER.
REQ-016 fifo_valid_o  output  1: valid toward the FIFO write port.
REQ-017 fifo_data_o  output  DATA_WIDTH: data toward the FIFO write port.
REQ-018 fifo_ready_i  input  1: FIFO not-full indication.

Function
REQ-019 FSM states: IDLE and XFER only.
REQ-020 IDLE: if any req_i bit is set, grant the first set bit searching round-robin from last_gnt+1, wrapping at NUM_REQ; latch its len_i into cnt; enter XFER next cycle with gnt_o one-hot.
REQ-021 IDLE outputs: gnt_o=0, ready_o=0, fifo_valid_o=0, busy_o=0.
REQ-022 XFER (selected index s): fifo_valid_o=valid_i[s] && req_i[s]; fifo_data_o=data_i slice s; ready_o[s]=fifo_ready_i; all other ready_o bits 0; all three paths combinational.
REQ-023 A beat is fifo_valid_o && fifo_ready_i; each beat with cnt!=0 decrements cnt by 1.
REQ-024 A beat with cnt==0 ends the burst: done_o[s] pulses the next cycle, state returns to IDLE, last_gnt<=s; a burst therefore carries exactly len+1 beats (1..2^LEN_WIDTH).
REQ-025 The burst is locked: no other requester is granted until completion or abort, regardless of competing req_i.
REQ-026 Rearbitration always passes through one IDLE cycle; minimum grant-to-grant spacing is burst length + 1 cycles.
REQ-027 req_i[s] deasserting in XFER, with no beat in that cycle, aborts: abort_o pulses next cycle, state returns to IDLE, last_gnt<=s, done_o stays 0.
REQ-028 fifo_ready_i low stalls with no counter change; valid_i[s] low inserts a bubble; neither causes an abort.
REQ-029 len_i is sampled only at grant; later changes have no effect on the active burst.
REQ-030 clr_i has priority over all events: next cycle state=IDLE, gnt_o=0, cnt=0, last_gnt=NUM_REQ-1, with no done_o or abort_o pulse.
REQ-031 done_o and abort_o are never high in the same cycle, and never high for more than one cycle.

Reset
REQ-032 rst_ni low forces asynchronously: state=IDLE, gnt_o=0, done_o=0, abort_o=0, busy_o=0, cnt=0, last_gnt=NUM_REQ-1 (requester 0 wins first).
REQ-033 While rst_ni is low or in the first IDLE cycle after release: fifo_valid_o=0 and ready_o=0.
REQ-034 Assertion of rst_ni mid-burst discards the burst and pulses neither done_o nor abort_o.

Verification
REQ-035 After reset, req_i=2'b11, both len=0, fifo_ready_i=1, valid_i=11 -> grant 0 (1 beat), done_o[0], IDLE, grant 1 (1 beat), done_o[1]; grants alternate on repeat.
REQ-036 Requester 1 with len=3, fifo_ready_i toggling every cycle -> exactly 4 beats, data delivered in order, done_o[1] one cycle after the 4th beat.
REQ-037 Requester 0 with len=15 while req_i[1] is held -> 16 consecutive beats from requester 0, ready_o[1]=0 throughout, then grant 1.
REQ-038 req_i[0] dropped after 2 of 5 beats -> abort_o pulse, done_o=0, requester 1 granted after the IDLE cycle.
REQ-039 clr_i asserted mid-burst -> gnt_o=0 next cycle with no pulse on done_o or abort_o; with req_i=11 the next grant goes to 0.
REQ-040 rst_ni asserted mid-burst with fifo_valid_o=1 -> all outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/spi_fifo_arbiter_if.sv
// spi_fifo_arbiter_if: requester/FIFO bundle for spi_fifo_arbiter.
// Requester side: clr_i, req_i, len_i, valid_i, data_i in; ready_o, gnt_o, done_o, abort_o, busy_o out.
// FIFO side: fifo_valid_o, fifo_data_o out; fifo_ready_i in.
// slave = arbiter view, master = environment view.
interface spi_fifo_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int LEN_WIDTH  = 4
) ();
  logic                          clr_i;
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*LEN_WIDTH-1:0]  len_i;
  logic [NUM_REQ-1:0]            valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_i;
  logic [NUM_REQ-1:0]            ready_o;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0]            done_o;
  logic                          abort_o;
  logic                          busy_o;
  logic                          fifo_valid_o;
  logic [DATA_WIDTH-1:0]         fifo_data_o;
  logic                          fifo_ready_i;
  modport slave (
    input  clr_i, req_i, len_i, valid_i, data_i, fifo_ready_i,
    output ready_o, gnt_o, done_o, abort_o, busy_o, fifo_valid_o, fifo_data_o
  );
  modport master (
    output clr_i, req_i, len_i, valid_i, data_i, fifo_ready_i,
    input  ready_o, gnt_o, done_o, abort_o, busy_o, fifo_valid_o, fifo_data_o
  );
endinterface

// File: rtl/spi_fifo_arbiter.sv
// spi_fifo_arbiter: round-robin, burst-locked arbiter of NUM_REQ requesters onto one FIFO write port.
// Ports: clk_i clock, rst_ni async active-low reset, bus (spi_fifo_arbiter_if.slave) carrying
// requests/lengths/data in, grants/ready/done/abort/busy out, and the FIFO valid/data/ready handshake.
module spi_fifo_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int LEN_WIDTH  = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  spi_fifo_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic {IDLE, XFER} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         sel_q, sel_d, last_q, last_d, pick, hi, lo;
  logic                  found_hi;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d, done_q, done_d;
  logic                  abort_q, abort_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, pick_len;
  logic                  req_s, valid_s, fv, beat, last_beat;
  logic [DATA_WIDTH-1:0] data_s;
  // Round robin: lowest requesting index above last_q, else lowest requesting index overall.
  always_comb begin
    hi = '0;
    lo = '0;
    found_hi = 1'b0;
    pick_len = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (bus.req_i[i]) begin
        lo = IW'(i);
        if (IW'(i) > last_q) begin
          hi = IW'(i);
          found_hi = 1'b1;
        end
      end
    pick = found_hi ? hi : lo;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick == IW'(i)) pick_len = bus.len_i[i*LEN_WIDTH +: LEN_WIDTH];
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = bus.clr_i ? IDLE :
              (state_q == IDLE) ? ((|bus.req_i) ? XFER : IDLE) :
              (last_beat || !req_s) ? IDLE : XFER;
  always_comb begin
    req_s = 1'b0;
    valid_s = 1'b0;
    data_s = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (sel_q == IW'(i)) begin
        req_s = bus.req_i[i];
        valid_s = bus.valid_i[i];
        data_s = bus.data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    fv = (state_q == XFER) && valid_s && req_s;
    beat = fv && bus.fifo_ready_i;
    last_beat = beat && (cnt_q == '0);
  end
  always_comb begin
    sel_d = sel_q;
    cnt_d = cnt_q;
    last_d = last_q;
    gnt_d = gnt_q;
    done_d = '0;
    abort_d = 1'b0;
    if (bus.clr_i) begin
      gnt_d = '0;
      cnt_d = '0;
      last_d = IW'(NUM_REQ - 1);
    end else if (state_q == IDLE) begin
      if (|bus.req_i) begin
        sel_d = pick;
        gnt_d = NUM_REQ'(1) << pick;
        cnt_d = pick_len;
      end
    end else if (last_beat) begin
      done_d = gnt_q;
      gnt_d = '0;
      last_d = sel_q;
    end else if (!req_s) begin
      // A dropped request never coincides with a beat, since fifo_valid_o needs req_i[s].
      abort_d = 1'b1;
      gnt_d = '0;
      last_d = sel_q;
    end else if (beat) cnt_d = cnt_q - 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      sel_q <= '0;
      cnt_q <= '0;
      last_q <= IW'(NUM_REQ - 1);
      gnt_q <= '0;
      done_q <= '0;
      abort_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      abort_q <= abort_d;
    end
  assign bus.fifo_valid_o = fv;
  assign bus.fifo_data_o  = data_s;
  assign bus.ready_o      = (state_q == XFER) ? (gnt_q & {NUM_REQ{bus.fifo_ready_i}}) : '0;
  assign bus.gnt_o        = gnt_q;
  assign bus.done_o       = done_q;
  assign bus.abort_o      = abort_q;
  assign bus.busy_o       = (state_q == XFER);
endmodule

// File: tb/tb_spi_fifo_arbiter.sv
// tb_spi_fifo_arbiter: directed self-checking bench for spi_fifo_arbiter (defaults: 32-bit data, 2 requesters, 4-bit len).
module tb_spi_fifo_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int passed = 0;
  int fails = 0;
  int beats;
  logic fr;
  spi_fifo_arbiter_if bus ();
  spi_fifo_arbiter dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.clr_i = 1'b0;
    bus.req_i = '0;
    bus.len_i = '0;
    bus.valid_i = '0;
    bus.data_i = '0;
    bus.fifo_ready_i = 1'b0;
    #1;
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_abort", bus.abort_o, 0);
    bus.req_i = 2'b11;
    bus.valid_i = 2'b11;
    bus.fifo_ready_i = 1'b1;
    bus.data_i = {32'hB1, 32'hA0};
    #1;
    chk("rst_fvalid", bus.fifo_valid_o, 0);
    chk("rst_ready", bus.ready_o, 0);
    tick;
    chk("rst_hold_gnt", bus.gnt_o, 0);
    rst_n = 1'b1;
    #1;
    chk("idle1_fvalid", bus.fifo_valid_o, 0);
    chk("idle1_ready", bus.ready_o, 0);
    // alternating single-beat grants
    tick;
    chk("rr_gnt0", bus.gnt_o, 2'b01);
    chk("rr_busy0", bus.busy_o, 1);
    chk("rr_fvalid0", bus.fifo_valid_o, 1);
    chk("rr_data0", bus.fifo_data_o, 32'hA0);
    chk("rr_ready0", bus.ready_o, 2'b01);
    tick;
    chk("rr_done0", bus.done_o, 2'b01);
    chk("rr_idle_gnt", bus.gnt_o, 0);
    chk("rr_idle_busy", bus.busy_o, 0);
    tick;
    chk("rr_gnt1", bus.gnt_o, 2'b10);
    chk("rr_done_clear", bus.done_o, 0);
    chk("rr_data1", bus.fifo_data_o, 32'hB1);
    chk("rr_ready1", bus.ready_o, 2'b10);
    tick;
    chk("rr_done1", bus.done_o, 2'b10);
    tick;
    chk("rr_gnt0_again", bus.gnt_o, 2'b01);
    tick;
    chk("rr_done0_again", bus.done_o, 2'b01);
    bus.req_i = 2'b00;
    tick;
    chk("rr_quiet", bus.gnt_o, 0);
    // requester 1, len 3, fifo_ready toggling
    bus.req_i = 2'b10;
    bus.len_i = {4'd3, 4'd0};
    tick;
    chk("st_gnt", bus.gnt_o, 2'b10);
    beats = 0;
    for (int c = 0; c < 8; c++) begin
      fr = c[0];
      bus.fifo_ready_i = fr;
      bus.data_i[63:32] = 32'h100 + beats;
      #1;
      chk("st_data", bus.fifo_data_o, 32'h100 + beats);
      chk("st_ready", bus.ready_o, {fr, 1'b0});
      chk("st_busy", bus.busy_o, 1);
      chk("st_done_early", bus.done_o, 0);
      tick;
      if (fr) beats++;
    end
    chk("st_done", bus.done_o, 2'b10);
    chk("st_abort", bus.abort_o, 0);
    bus.req_i = 2'b00;
    bus.fifo_ready_i = 1'b1;
    tick;
    // requester 0, len 15, requester 1 competing; len change mid-burst ignored
    bus.req_i = 2'b11;
    bus.len_i = {4'd0, 4'd15};
    tick;
    chk("lk_gnt0", bus.gnt_o, 2'b01);
    for (int i = 0; i < 16; i++) begin
      bus.data_i[31:0] = 32'h200 + i;
      if (i == 3) bus.len_i[3:0] = 4'd0;
      #1;
      chk("lk_gnt", bus.gnt_o, 2'b01);
      chk("lk_ready", bus.ready_o, 2'b01);
      chk("lk_data", bus.fifo_data_o, 32'h200 + i);
      chk("lk_done_early", bus.done_o, 0);
      tick;
    end
    chk("lk_done", bus.done_o, 2'b01);
    chk("lk_idle_gnt", bus.gnt_o, 0);
    tick;
    chk("lk_gnt1", bus.gnt_o, 2'b10);
    chk("lk_ready1", bus.ready_o, 2'b10);
    tick;
    chk("lk_done1", bus.done_o, 2'b10);
    bus.req_i = 2'b00;
    tick;
    // abort of requester 0 after 2 of 5 beats
    bus.req_i = 2'b11;
    bus.len_i = {4'd0, 4'd4};
    tick;
    chk("ab_gnt0", bus.gnt_o, 2'b01);
    chk("ab_fvalid", bus.fifo_valid_o, 1);
    tick;
    tick;
    bus.req_i = 2'b10;
    #1;
    chk("ab_fvalid_drop", bus.fifo_valid_o, 0);
    chk("ab_abort_early", bus.abort_o, 0);
    tick;
    chk("ab_abort", bus.abort_o, 1);
    chk("ab_done", bus.done_o, 0);
    chk("ab_gnt_idle", bus.gnt_o, 0);
    chk("ab_busy", bus.busy_o, 0);
    tick;
    chk("ab_gnt1", bus.gnt_o, 2'b10);
    chk("ab_abort_pulse", bus.abort_o, 0);
    tick;
    chk("ab_done1", bus.done_o, 2'b10);
    bus.req_i = 2'b00;
    tick;
    // clear mid-burst restores requester 0 priority
    bus.req_i = 2'b01;
    bus.len_i = 8'h00;
    tick;
    chk("cl_gnt0", bus.gnt_o, 2'b01);
    tick;
    chk("cl_done0", bus.done_o, 2'b01);
    bus.req_i = 2'b11;
    bus.len_i = {4'd5, 4'd0};
    tick;
    chk("cl_gnt1", bus.gnt_o, 2'b10);
    tick;
    bus.clr_i = 1'b1;
    tick;
    chk("cl_gnt", bus.gnt_o, 0);
    chk("cl_done", bus.done_o, 0);
    chk("cl_abort", bus.abort_o, 0);
    chk("cl_busy", bus.busy_o, 0);
    bus.clr_i = 1'b0;
    bus.len_i = {4'd5, 4'd5};
    tick;
    chk("cl_regrant0", bus.gnt_o, 2'b01);
    chk("cl_pulse", bus.abort_o, 0);
    // asynchronous reset mid-burst
    tick;
    chk("ar_fvalid_pre", bus.fifo_valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("ar_gnt", bus.gnt_o, 0);
    chk("ar_fvalid", bus.fifo_valid_o, 0);
    chk("ar_busy", bus.busy_o, 0);
    chk("ar_ready", bus.ready_o, 0);
    chk("ar_done", bus.done_o, 0);
    chk("ar_abort", bus.abort_o, 0);
    tick;
    tick;
    rst_n = 1'b1;
    #1;
    chk("ar_rel_done", bus.done_o, 0);
    chk("ar_rel_abort", bus.abort_o, 0);
    chk("ar_rel_fvalid", bus.fifo_valid_o, 0);
    tick;
    chk("ar_regrant0", bus.gnt_o, 2'b01);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
